// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the RV64 datapath/memories.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [31:0] instruction;
    logic        imem_ready;
    logic        dmem_ready;

    logic        PCWrite;
    logic        PCWriteCond;
    logic        BranchNe;
    logic [1:0]  PCSource;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic        LoadAOut;
    logic        RegWrite;
    logic        LoadRegA;
    logic        LoadRegB;
    logic [1:0]  RegSrc;
    logic        DMemRead;
    logic        DMemWrite;
    logic        LoadMDR;
    logic        IMemRead;
    logic        IRWrite;
    logic        instr_retired;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state_dbg;

    modport master (
        input  instruction, imem_ready, dmem_ready,
        output PCWrite, PCWriteCond, BranchNe, PCSource, ALUSrcA, ALUSrcB, ALUOp,
               LoadAOut, RegWrite, LoadRegA, LoadRegB, RegSrc, DMemRead, DMemWrite,
               LoadMDR, IMemRead, IRWrite, instr_retired, trap, trap_cause, state_dbg
    );

    modport slave (
        output instruction, imem_ready, dmem_ready,
        input  PCWrite, PCWriteCond, BranchNe, PCSource, ALUSrcA, ALUSrcB, ALUOp,
               LoadAOut, RegWrite, LoadRegA, LoadRegB, RegSrc, DMemRead, DMemWrite,
               LoadMDR, IMemRead, IRWrite, instr_retired, trap, trap_cause, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the RV64 subset datapath: sequences datapath flags,
// waits on imem/dmem ready with a bounded timeout, and traps on illegal opcodes.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter bit ENABLE_JAL     = 1'b1
) (
    input logic           clk,
    input logic           reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_LD   = 4'd3,
        MEM_SD   = 4'd4,
        WB_MEM   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        LUI      = 4'd10,
        JAL      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       BranchNe;
        logic [1:0] PCSource;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic       LoadAOut;
        logic       RegWrite;
        logic       LoadRegA;
        logic       LoadRegB;
        logic [1:0] RegSrc;
        logic       DMemRead;
        logic       DMemWrite;
        logic       LoadMDR;
        logic       IMemRead;
        logic       IRWrite;
        logic       instrRetired;
    } ctrl_t;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // A zero timeout still needs a 1-bit counter to keep the logic legal; it just never counts.
    localparam int            CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    state_t        state, nextState;
    logic [CW-1:0] waitCount;
    logic [1:0]    cause, nextCause;
    ctrl_t         ctrl, ctrlOut;
    logic          memWait, timedOut, illegal;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          unusedInstr;

    assign opcode      = bus.instruction[6:0];
    assign funct3      = bus.instruction[14:12];
    assign unusedInstr = ^{bus.instruction[31:15], bus.instruction[11:7]};

    always_comb begin
        memWait  = ((state == FETCH) && !bus.imem_ready) ||
                   (((state == MEM_LD) || (state == MEM_SD)) && !bus.dmem_ready);
        timedOut = TO_EN && memWait && (waitCount == TO_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            waitCount <= '0;
            cause     <= 2'b00;
        end else begin
            state <= nextState;
            cause <= nextCause;
            // Any state change clears the count, so each wait state starts fresh on entry.
            if (nextState != state)
                waitCount <= '0;
            else if (TO_EN && memWait && (waitCount != TO_MAX))
                waitCount <= waitCount + 1'b1;
        end
    end

    always_comb begin
        ctrl      = '0;
        nextState = state;
        nextCause = cause;
        illegal   = 1'b0;
        case (state)
            FETCH: begin
                ctrl.IMemRead = 1'b1;
                if (bus.imem_ready) begin
                    ctrl.IRWrite = 1'b1;
                    ctrl.PCWrite = 1'b1;
                    ctrl.ALUSrcB = 2'b01;
                    nextState    = DECODE;
                end else if (timedOut) begin
                    nextState = TRAP;
                    nextCause = 2'b10;
                end
            end
            DECODE: begin
                ctrl.LoadRegA = 1'b1;
                ctrl.LoadRegB = 1'b1;
                ctrl.LoadAOut = 1'b1;
                ctrl.ALUSrcB  = 2'b11;
                case (opcode)
                    OP_LD, OP_SD: nextState = MEM_ADDR;
                    OP_R:         nextState = EXEC_R;
                    OP_I:         nextState = EXEC_I;
                    OP_BR:        if (funct3[2:1] == 2'b00) nextState = BRANCH; else illegal = 1'b1;
                    OP_LUI:       nextState = LUI;
                    OP_JAL:       if (ENABLE_JAL) nextState = JAL; else illegal = 1'b1;
                    default:      illegal = 1'b1;
                endcase
                if (illegal) begin
                    nextState = TRAP;
                    nextCause = 2'b01;
                end
            end
            MEM_ADDR: begin
                ctrl.LoadAOut = 1'b1;
                ctrl.ALUSrcA  = 1'b1;
                ctrl.ALUSrcB  = 2'b10;
                nextState     = (opcode == OP_SD) ? MEM_SD : MEM_LD;
            end
            MEM_LD: begin
                ctrl.DMemRead = 1'b1;
                if (bus.dmem_ready) begin
                    ctrl.LoadMDR = 1'b1;
                    nextState    = WB_MEM;
                end else if (timedOut) begin
                    nextState = TRAP;
                    nextCause = 2'b11;
                end
            end
            MEM_SD: begin
                ctrl.DMemWrite = 1'b1;
                if (bus.dmem_ready) begin
                    ctrl.instrRetired = 1'b1;
                    nextState         = FETCH;
                end else if (timedOut) begin
                    nextState = TRAP;
                    nextCause = 2'b11;
                end
            end
            WB_MEM: begin
                ctrl.RegWrite     = 1'b1;
                ctrl.RegSrc       = 2'b01;
                ctrl.instrRetired = 1'b1;
                nextState         = FETCH;
            end
            EXEC_R: begin
                ctrl.LoadAOut = 1'b1;
                ctrl.ALUSrcA  = 1'b1;
                ctrl.ALUOp    = 2'b10;
                nextState     = WB_ALU;
            end
            EXEC_I: begin
                ctrl.LoadAOut = 1'b1;
                ctrl.ALUSrcA  = 1'b1;
                ctrl.ALUSrcB  = 2'b10;
                ctrl.ALUOp    = 2'b11;
                nextState     = WB_ALU;
            end
            WB_ALU: begin
                ctrl.RegWrite     = 1'b1;
                ctrl.instrRetired = 1'b1;
                nextState         = FETCH;
            end
            BRANCH: begin
                ctrl.PCWriteCond  = 1'b1;
                ctrl.PCSource     = 2'b01;
                ctrl.ALUSrcA      = 1'b1;
                ctrl.ALUOp        = 2'b01;
                ctrl.BranchNe     = funct3[0];
                ctrl.instrRetired = 1'b1;
                nextState         = FETCH;
            end
            LUI: begin
                ctrl.RegWrite     = 1'b1;
                ctrl.RegSrc       = 2'b11;
                ctrl.instrRetired = 1'b1;
                nextState         = FETCH;
            end
            JAL: begin
                ctrl.RegWrite     = 1'b1;
                ctrl.RegSrc       = 2'b10;
                ctrl.PCWrite      = 1'b1;
                ctrl.PCSource     = 2'b10;
                ctrl.instrRetired = 1'b1;
                nextState         = FETCH;
            end
            TRAP:    nextState = TRAP;
            default: nextState = FETCH;
        endcase
    end

    // Reset overrides everything combinationally so no write strobe leaks out mid-instruction.
    assign ctrlOut = reset ? '0 : ctrl;

    assign bus.PCWrite       = ctrlOut.PCWrite;
    assign bus.PCWriteCond   = ctrlOut.PCWriteCond;
    assign bus.BranchNe      = ctrlOut.BranchNe;
    assign bus.PCSource      = ctrlOut.PCSource;
    assign bus.ALUSrcA       = ctrlOut.ALUSrcA;
    assign bus.ALUSrcB       = ctrlOut.ALUSrcB;
    assign bus.ALUOp         = ctrlOut.ALUOp;
    assign bus.LoadAOut      = ctrlOut.LoadAOut;
    assign bus.RegWrite      = ctrlOut.RegWrite;
    assign bus.LoadRegA      = ctrlOut.LoadRegA;
    assign bus.LoadRegB      = ctrlOut.LoadRegB;
    assign bus.RegSrc        = ctrlOut.RegSrc;
    assign bus.DMemRead      = ctrlOut.DMemRead;
    assign bus.DMemWrite     = ctrlOut.DMemWrite;
    assign bus.LoadMDR       = ctrlOut.LoadMDR;
    assign bus.IMemRead      = ctrlOut.IMemRead;
    assign bus.IRWrite       = ctrlOut.IRWrite;
    assign bus.instr_retired = ctrlOut.instrRetired;
    assign bus.trap          = !reset && (state == TRAP);
    assign bus.trap_cause    = reset ? 2'b00 : cause;
    assign bus.state_dbg     = reset ? 4'd0 : state;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed latency table, reset/timeout sequences and
// random instruction streams checked cycle by cycle against a per-instruction trace model.
module tb_multicycle_control;
    localparam int TO = 3;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();
    multicycle_control_if bus0 ();

    multicycle_control #(.TIMEOUT_CYCLES(TO), .ENABLE_JAL(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    multicycle_control #(.TIMEOUT_CYCLES(0), .ENABLE_JAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       BranchNe;
        logic [1:0] PCSource;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic       LoadAOut;
        logic       RegWrite;
        logic       LoadRegA;
        logic       LoadRegB;
        logic [1:0] RegSrc;
        logic       DMemRead;
        logic       DMemWrite;
        logic       LoadMDR;
        logic       IMemRead;
        logic       IRWrite;
        logic       instr_retired;
        logic       trap;
        logic [1:0] trap_cause;
    } ctl_t;

    ctl_t act, act0;
    assign act  = {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.PCSource, bus.ALUSrcA,
                   bus.ALUSrcB, bus.ALUOp, bus.LoadAOut, bus.RegWrite, bus.LoadRegA, bus.LoadRegB,
                   bus.RegSrc, bus.DMemRead, bus.DMemWrite, bus.LoadMDR, bus.IMemRead,
                   bus.IRWrite, bus.instr_retired, bus.trap, bus.trap_cause};
    assign act0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.BranchNe, bus0.PCSource, bus0.ALUSrcA,
                   bus0.ALUSrcB, bus0.ALUOp, bus0.LoadAOut, bus0.RegWrite, bus0.LoadRegA,
                   bus0.LoadRegB, bus0.RegSrc, bus0.DMemRead, bus0.DMemWrite, bus0.LoadMDR,
                   bus0.IMemRead, bus0.IRWrite, bus0.instr_retired, bus0.trap, bus0.trap_cause};

    typedef enum int {P_FW, P_FG, P_DEC, P_MA, P_LW, P_LG, P_SW, P_SG, P_WBM,
                      P_XR, P_XI, P_WBA, P_BR, P_LUI, P_JAL, P_TRAP} ph_t;

    typedef struct {
        logic imr;
        logic dmr;
        ctl_t exp;
    } vec_t;

    typedef struct {
        logic [31:0] ins;
        int          iw;
        int          dw;
        int          expRet;
        logic [1:0]  expCause;
    } case_t;

    vec_t  tr[$];
    case_t cases[18];

    // Control word each instruction phase must present, straight from the flag table.
    function automatic ctl_t word(ph_t p, logic [1:0] arg);
        ctl_t w;
        w = '0;
        case (p)
            P_FW:  w.IMemRead = 1'b1;
            P_FG:  begin w.IMemRead = 1'b1; w.IRWrite = 1'b1; w.PCWrite = 1'b1; w.ALUSrcB = 2'b01; end
            P_DEC: begin w.LoadRegA = 1'b1; w.LoadRegB = 1'b1; w.LoadAOut = 1'b1; w.ALUSrcB = 2'b11; end
            P_MA:  begin w.LoadAOut = 1'b1; w.ALUSrcA = 1'b1; w.ALUSrcB = 2'b10; end
            P_LW:  w.DMemRead = 1'b1;
            P_LG:  begin w.DMemRead = 1'b1; w.LoadMDR = 1'b1; end
            P_SW:  w.DMemWrite = 1'b1;
            P_SG:  begin w.DMemWrite = 1'b1; w.instr_retired = 1'b1; end
            P_WBM: begin w.RegWrite = 1'b1; w.RegSrc = 2'b01; w.instr_retired = 1'b1; end
            P_XR:  begin w.LoadAOut = 1'b1; w.ALUSrcA = 1'b1; w.ALUOp = 2'b10; end
            P_XI:  begin w.LoadAOut = 1'b1; w.ALUSrcA = 1'b1; w.ALUSrcB = 2'b10; w.ALUOp = 2'b11; end
            P_WBA: begin w.RegWrite = 1'b1; w.instr_retired = 1'b1; end
            P_BR:  begin
                w.PCWriteCond = 1'b1; w.PCSource = 2'b01; w.ALUSrcA = 1'b1; w.ALUOp = 2'b01;
                w.BranchNe = arg[0]; w.instr_retired = 1'b1;
            end
            P_LUI: begin w.RegWrite = 1'b1; w.RegSrc = 2'b11; w.instr_retired = 1'b1; end
            P_JAL: begin
                w.RegWrite = 1'b1; w.RegSrc = 2'b10; w.PCWrite = 1'b1; w.PCSource = 2'b10;
                w.instr_retired = 1'b1;
            end
            P_TRAP: begin w.trap = 1'b1; w.trap_cause = arg; end
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic push(input logic imr, input logic dmr, input ph_t p, input logic [1:0] arg);
        vec_t v;
        v.imr = imr;
        v.dmr = dmr;
        v.exp = word(p, arg);
        tr.push_back(v);
    endtask

    task automatic setInstr(input logic [31:0] ins);
        bus.instruction  = ins;
        bus0.instruction = ins;
    endtask

    task automatic setReady(input logic imr, input logic dmr);
        bus.imem_ready  = imr;
        bus.dmem_ready  = dmr;
        bus0.imem_ready = imr;
        bus0.dmem_ready = dmr;
    endtask

    // Expected cycle trace of one instruction for the TO=3, JAL-enabled controller,
    // given how many not-ready cycles each memory stalls for.
    task automatic plan(input logic [31:0] ins, input int iw, input int dw, input int trapLen,
                        output bit trapped);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        trapped = 1'b0;
        tr.delete();
        for (int i = 0; i < iw && i <= TO; i++) push(1'b0, rb(), P_FW, 2'b00);
        if (iw > TO) begin
            repeat (trapLen) push(rb(), rb(), P_TRAP, 2'b10);
            trapped = 1'b1;
            return;
        end
        push(1'b1, rb(), P_FG, 2'b00);
        push(rb(), rb(), P_DEC, 2'b00);
        if (op == OP_LD || op == OP_SD) begin
            push(rb(), rb(), P_MA, 2'b00);
            for (int i = 0; i < dw && i <= TO; i++)
                push(rb(), 1'b0, (op == OP_SD) ? P_SW : P_LW, 2'b00);
            if (dw > TO) begin
                repeat (trapLen) push(rb(), rb(), P_TRAP, 2'b11);
                trapped = 1'b1;
                return;
            end
            push(rb(), 1'b1, (op == OP_SD) ? P_SG : P_LG, 2'b00);
            if (op == OP_LD) push(rb(), rb(), P_WBM, 2'b00);
        end else if (op == OP_R) begin
            push(rb(), rb(), P_XR, 2'b00);
            push(rb(), rb(), P_WBA, 2'b00);
        end else if (op == OP_I) begin
            push(rb(), rb(), P_XI, 2'b00);
            push(rb(), rb(), P_WBA, 2'b00);
        end else if (op == OP_BR && f3 < 3'd2) begin
            push(rb(), rb(), P_BR, {1'b0, f3[0]});
        end else if (op == OP_LUI) begin
            push(rb(), rb(), P_LUI, 2'b00);
        end else if (op == OP_JAL) begin
            push(rb(), rb(), P_JAL, 2'b00);
        end else begin
            repeat (trapLen) push(rb(), rb(), P_TRAP, 2'b01);
            trapped = 1'b1;
        end
    endtask

    task automatic runTrace(input string nm, input bit sel, output int retAt, output int nRet,
                            output logic [1:0] lastCause);
        ctl_t a;
        retAt     = -1;
        nRet      = 0;
        lastCause = 2'b00;
        foreach (tr[i]) begin
            setReady(tr[i].imr, tr[i].dmr);
            @(negedge clk);
            a = sel ? act0 : act;
            chk($sformatf("%s.cyc%0d", nm, i + 1), 32'(a), 32'(tr[i].exp));
            if (tr[i].exp.IMemRead)
                chk($sformatf("%s.fetchdbg%0d", nm, i + 1),
                    32'(sel ? bus0.state_dbg : bus.state_dbg), 32'd0);
            if (a.instr_retired) begin
                nRet++;
                if (retAt < 0) retAt = i + 1;
            end
            if (a.trap) lastCause = a.trap_cause;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        repeat (n) begin
            setReady(rb(), rb());
            @(negedge clk);
            chk("reset.flags", 32'(act), 32'd0);
            chk("reset.flags0", 32'(act0), 32'd0);
            chk("reset.dbg", 32'(bus.state_dbg), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int         retAt, nRet;
        logic [1:0] lastCause;
        bit         trapped;
        logic [8:0] retMask, rwMask;
        logic [6:0] ops[9];
        logic [31:0] ins;

        cases[0]  = '{32'h0000_0033, 0, 0, 4, 2'b00};  // ADD
        cases[1]  = '{32'h0000_0013, 0, 0, 4, 2'b00};  // ADDI
        cases[2]  = '{32'h0000_3003, 0, 0, 5, 2'b00};  // LD
        cases[3]  = '{32'h0000_3003, 0, 3, 8, 2'b00};  // LD, 3 dmem waits
        cases[4]  = '{32'h0000_3023, 0, 0, 4, 2'b00};  // SD
        cases[5]  = '{32'h0000_3023, 0, 3, 7, 2'b00};  // SD ready on 4th wait cycle
        cases[6]  = '{32'h0000_0063, 0, 0, 3, 2'b00};  // BEQ
        cases[7]  = '{32'h0000_1063, 0, 0, 3, 2'b00};  // BNE
        cases[8]  = '{32'h1234_5037, 0, 0, 3, 2'b00};  // LUI
        cases[9]  = '{32'h0000_006f, 0, 0, 3, 2'b00};  // JAL
        cases[10] = '{32'h0000_0033, 2, 0, 6, 2'b00};  // ADD, 2 imem waits
        cases[11] = '{32'h0000_3003, 1, 1, 7, 2'b00};  // LD, 1+1 waits
        cases[12] = '{32'h0000_007f, 0, 0, -1, 2'b01}; // illegal opcode
        cases[13] = '{32'h0000_2063, 0, 0, -1, 2'b01}; // branch funct3 010
        cases[14] = '{32'h0000_0033, 4, 0, -1, 2'b10}; // imem timeout
        cases[15] = '{32'h0000_3003, 0, 4, -1, 2'b11}; // LD dmem timeout
        cases[16] = '{32'h0000_3023, 0, 6, -1, 2'b11}; // SD dmem timeout
        cases[17] = '{32'h0000_0033, 3, 0, 7, 2'b00};  // imem ready at count==TO

        setInstr(32'h0000_0033);
        setReady(1'b0, 1'b0);
        doReset(3);

        foreach (cases[k]) begin
            setInstr(cases[k].ins);
            plan(cases[k].ins, cases[k].iw, cases[k].dw, (cases[k].expCause == 2'b01) ? 20 : 3, trapped);
            runTrace($sformatf("case%0d", k), 1'b0, retAt, nRet, lastCause);
            chk($sformatf("case%0d.latency", k), 32'(retAt), 32'(cases[k].expRet));
            chk($sformatf("case%0d.retires", k), 32'(nRet), (cases[k].expRet > 0) ? 32'd1 : 32'd0);
            chk($sformatf("case%0d.cause", k), 32'(lastCause), 32'(cases[k].expCause));
            if (trapped) doReset(1);
        end

        // Two ADDs with ready tied high: retire at cycles 4 and 8 after reset release.
        setInstr(32'h0000_0033);
        doReset(2);
        setReady(1'b1, 1'b1);
        retMask = '0;
        rwMask  = '0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            retMask[c] = bus.instr_retired;
            rwMask[c]  = bus.RegWrite && (bus.RegSrc == 2'b00);
            @(posedge clk);
            #1;
        end
        chk("add2.retire", 32'(retMask), 32'h088);
        chk("add2.regwrite", 32'(rwMask), 32'h088);

        // Reset during MEM_LD drops everything and restarts at FETCH.
        setInstr(32'h0000_3003);
        doReset(1);
        tr.delete();
        push(1'b1, 1'b0, P_FG, 2'b00);
        push(1'b0, 1'b0, P_DEC, 2'b00);
        push(1'b0, 1'b0, P_MA, 2'b00);
        push(1'b0, 1'b0, P_LW, 2'b00);
        runTrace("ldreset", 1'b0, retAt, nRet, lastCause);
        reset = 1'b1;
        setReady(1'b1, 1'b1);
        @(negedge clk);
        chk("ldreset.flags", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        setReady(1'b0, 1'b1);
        @(negedge clk);
        chk("ldreset.fetch", 32'(act), 32'(word(P_FW, 2'b00)));
        chk("ldreset.dbg", 32'(bus.state_dbg), 32'd0);
        @(posedge clk);
        #1;

        // No-timeout, JAL-disabled instance: long imem stall is tolerated, JAL traps illegal.
        setInstr(32'h0000_006f);
        doReset(1);
        tr.delete();
        repeat (25) push(1'b0, rb(), P_FW, 2'b00);
        push(1'b1, rb(), P_FG, 2'b00);
        push(rb(), rb(), P_DEC, 2'b00);
        repeat (3) push(rb(), rb(), P_TRAP, 2'b01);
        runTrace("nojal", 1'b1, retAt, nRet, lastCause);
        chk("nojal.retires", 32'(nRet), 32'd0);
        chk("nojal.cause", 32'(lastCause), 32'd1);

        // Random instruction stream with random memory stalls, including timeouts.
        ops = '{OP_LD, OP_SD, OP_R, OP_I, OP_BR, OP_LUI, OP_JAL, 7'h7f, 7'h0b};
        doReset(1);
        for (int n = 0; n < 120; n++) begin
            int iw, dw;
            ins      = $urandom;
            ins[6:0] = ops[$urandom_range(8, 0)];
            iw = ($urandom_range(7, 0) == 0) ? TO + 1 : int'($urandom_range(TO, 0));
            dw = ($urandom_range(7, 0) == 0) ? TO + 1 + int'($urandom_range(1, 0))
                                             : int'($urandom_range(TO, 0));
            setInstr(ins);
            plan(ins, iw, dw, 2, trapped);
            runTrace($sformatf("rnd%0d", n), 1'b0, retAt, nRet, lastCause);
            chk($sformatf("rnd%0d.retires", n), 32'(nRet), trapped ? 32'd0 : 32'd1);
            if (trapped) doReset(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
